// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : Instruction-fetch front end. Owns the PC, drives the instruction
//            memory address and fills the IF/ID register under a valid/ready
//            handshake with redirects from execute.
//            Optional macro FETCH_MISALIGN_TRAP_EN: misaligned redirects raise
//            a sticky fault that halts fetch until reset.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4,
    output logic        misalign_fault
);

    localparam logic [31:0] c_pc_step = 32'd4;

    logic [31:0] r_pc;
    logic        r_id_valid;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc_plus4;

    logic        w_slot_free;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_redirect_target;
    logic        w_halt;

    assign w_slot_free       = !r_id_valid || id_ready;
    assign w_pc_plus4        = r_pc + c_pc_step;
    assign w_redirect_target = {redirect_pc[31:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
    logic r_fault;
    logic w_trap;

    // A misaligned redirect is diverted into the fault path instead of moving the PC.
    assign w_trap = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign w_halt = r_fault || w_trap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fault <= 1'b0;
        end else if (w_trap) begin
            r_fault <= 1'b1;
        end
    end

    assign misalign_fault = r_fault;
`else
    logic w_unused_lowbits;

    assign w_unused_lowbits = ^redirect_pc[1:0];
    assign w_halt           = 1'b0;
    assign misalign_fault   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_id_valid    <= 1'b0;
            r_id_pc       <= 32'd0;
            r_id_instr    <= 32'd0;
            r_id_pc_plus4 <= 32'd0;
        end else if (w_halt) begin
            r_id_valid    <= 1'b0;
        end else if (redirect_valid) begin
            // Squashes both the held slot and the word currently on imem_instr.
            r_pc          <= w_redirect_target;
            r_id_valid    <= 1'b0;
        end else if (w_slot_free) begin
            r_id_pc       <= r_pc;
            r_id_instr    <= imem_instr;
            r_id_pc_plus4 <= w_pc_plus4;
            r_id_valid    <= 1'b1;
            r_pc          <= w_pc_plus4;
        end
    end

    assign imem_addr   = r_pc;
    assign id_valid    = r_id_valid;
    assign id_pc       = r_id_pc;
    assign id_instr    = r_id_instr;
    assign id_pc_plus4 = r_id_pc_plus4;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Self-checking bench for fetch_stage: directed scenarios followed by
//            randomized ready/redirect/reset traffic against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] c_reset_pc = 32'h00000000;
    localparam logic [31:0] c_mem_key  = 32'hA5A5A5A5;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;
    logic        misalign_fault;

    int checks;
    int failures;

    // Reference model state
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_id_pc;
    logic [31:0] m_id_instr;
    logic        m_fault;

    fetch_stage #(.RESET_PC(c_reset_pc)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .id_pc_plus4    (id_pc_plus4),
        .misalign_fault (misalign_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory
    assign imem_instr = imem_addr ^ c_mem_key;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic misaligned_traps(input logic [31:0] target);
`ifdef FETCH_MISALIGN_TRAP_EN
        return target[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_pc       = c_reset_pc;
        m_valid    = 1'b0;
        m_id_pc    = 32'd0;
        m_id_instr = 32'd0;
        m_fault    = 1'b0;
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else if (m_fault) begin
            m_valid = 1'b0;
        end else if (redirect_valid) begin
            m_valid = 1'b0;
            if (misaligned_traps(redirect_pc)) m_fault = 1'b1;
            else                               m_pc = redirect_pc & ~32'd3;
        end else if (!m_valid || id_ready) begin
            m_id_pc    = m_pc;
            m_id_instr = m_pc ^ c_mem_key;
            m_valid    = 1'b1;
            m_pc       = m_pc + 32'd4;
        end
    endtask

    task automatic check_all();
        chk("imem_addr",   imem_addr,             m_pc);
        chk("id_valid",    {31'd0, id_valid},     {31'd0, m_valid});
        chk("id_pc",       id_pc,                 m_id_pc);
        chk("id_instr",    id_instr,              m_id_instr);
        chk("id_pc_plus4", id_pc_plus4,           (rst || (m_id_pc == 32'd0 && m_id_instr == 32'd0)) ? 32'd0 : m_id_pc + 32'd4);
        chk("fault",       {31'd0, misalign_fault}, {31'd0, m_fault});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst            = 1'b1;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        model_reset();

        // Reset state
        #1;
        chk("rst_addr",  imem_addr,         c_reset_pc);
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        step();
        step();

        // Free-run from reset
        rst      = 1'b0;
        id_ready = 1'b1;
        step(); chk("run0_pc", id_pc, 32'h0); chk("run0_instr", id_instr, 32'h0 ^ c_mem_key);
        step(); chk("run1_pc", id_pc, 32'h4);
        step(); chk("run2_pc", id_pc, 32'h8);

        // Stall with id_pc = 8 held
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", id_pc, 32'h8);
            chk("stall_addr", imem_addr, 32'hC);
        end
        id_ready = 1'b1;
        step(); chk("unstall_pc", id_pc, 32'hC);

        // Redirect under stall
        id_ready       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        chk("redir_valid", {31'd0, id_valid}, 32'd0);
        chk("redir_addr",  imem_addr,         32'h100);
        redirect_valid = 1'b0;
        step(); chk("redir_pc", id_pc, 32'h100);

        // PC wrap
        id_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFFFFFC;
        step();
        redirect_valid = 1'b0;
        step();
        chk("wrap_pc",    id_pc,       32'hFFFFFFFC);
        chk("wrap_plus4", id_pc_plus4, 32'h0);
        step(); chk("wrap_next", id_pc, 32'h0);

        // Async reset mid-stream at pc = 0x20
        while (m_pc != 32'h20) step();
        #2;
        rst = 1'b1;
        #1;
        chk("async_valid", {31'd0, id_valid}, 32'd0);
        chk("async_addr",  imem_addr,         c_reset_pc);
        model_reset();
        step();
        rst = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            id_ready       = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = $urandom;
            if ($urandom_range(0, 3) != 0) redirect_pc[1:0] = 2'b00;
            rst            = ($urandom_range(0, 99) == 0);
            step();
        end

        // Misaligned redirect
        rst            = 1'b1;
        redirect_valid = 1'b0;
        step();
        rst      = 1'b0;
        id_ready = 1'b1;
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        step();
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_fault", {31'd0, misalign_fault}, 32'd1);
        chk("mis_valid", {31'd0, id_valid},       32'd0);
        chk("mis_addr",  imem_addr,               32'h8);
        step();
        chk("mis_hold_valid", {31'd0, id_valid}, 32'd0);
        chk("mis_hold_addr",  imem_addr,         32'h8);
`else
        chk("mis_addr",  imem_addr,               32'h100);
        chk("mis_fault", {31'd0, misalign_fault}, 32'd0);
        step();
        chk("mis_next_pc", id_pc, 32'h100);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
